// File: rtl/rn_hbm_pkg.sv
// Shared types and constants for the HBM power-up sequencer.
package rn_hbm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_HOLD  = 3'd1,
    ST_POLL_AR   = 3'd2,
    ST_POLL_R    = 3'd3,
    ST_POLL_WAIT = 3'd4,
    ST_READY     = 3'd5,
    ST_ERROR     = 3'd6
  } hbm_seq_state_t;

  localparam logic [1:0]  AXIL_RESP_OKAY = 2'b00;
  localparam logic [31:0] CAL_ADDR_DEF   = 32'h0010_0000;
  localparam logic [31:0] CAL_MASK_DEF   = 32'h0000_0003;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hbm_powerup_sequencer_if.sv
// Read-only AXI-Lite channel used to poll the HBM calibration status register.
interface hbm_powerup_sequencer_if;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (output arvalid, araddr, rready,
                  input  arready, rvalid, rdata, rresp);
  modport slave  (input  arvalid, araddr, rready,
                  output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync_2ff (
  input  logic axis_clk,
  input  logic axis_rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hbm_powerup_sequencer.sv
// HBM bring-up: hold reset after clock lock, poll calibration over AXI-Lite,
// then release powerup_rstn and pulse start_config.
//   state        | meaning
//   IDLE         | waiting for synchronized HBM clock lock
//   RST_HOLD     | holding HBM subsystem in reset for RST_CYCLES
//   POLL_AR      | calibration read address issued
//   POLL_R       | waiting for calibration read data
//   POLL_WAIT    | idle gap between calibration reads
//   READY        | calibrated, powerup_rstn released
//   ERROR        | timeout or slave error, sticky until axis_rstn
module hbm_powerup_sequencer
  import rn_hbm_pkg::*;
#(
  parameter int          RST_CYCLES    = 15000,
  parameter int          POLL_INTERVAL = 256,
  parameter int          POLL_MAX      = 64,
  parameter logic [31:0] CAL_ADDR      = CAL_ADDR_DEF,
  parameter logic [31:0] CAL_MASK      = CAL_MASK_DEF
) (
  input  logic                           axis_clk,
  input  logic                           axis_rstn,
  input  logic                           i_hbm_clk_locked,
  hbm_powerup_sequencer_if.master        m_axil,
  output logic                           o_powerup_rstn,
  output logic                           o_start_config,
  output logic                           o_seq_error,
  output logic [2:0]                     o_seq_state
);

  localparam int CNT_W  = $clog2(max_int(RST_CYCLES, POLL_INTERVAL)) + 1;
  localparam int PCNT_W = $clog2(POLL_MAX) + 1;
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_MAX - 1);

  hbm_seq_state_t    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PCNT_W-1:0] r_poll_cnt;
  logic              r_lost;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_powerup_rstn;
  logic              r_start_config;
  logic              r_seq_error;
  logic              w_lock_s;
  logic              w_cal_done;

  sync_2ff u_lock_sync (
    .axis_clk  (axis_clk),
    .axis_rstn (axis_rstn),
    .i_d       (i_hbm_clk_locked),
    .o_q       (w_lock_s)
  );

  assign w_cal_done = (m_axil.rdata & CAL_MASK) == CAL_MASK;

  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_poll_cnt     <= '0;
      r_lost         <= 1'b0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_powerup_rstn <= 1'b0;
      r_start_config <= 1'b0;
      r_seq_error    <= 1'b0;
    end else begin
      r_start_config <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_lock_s) begin
            r_cnt   <= '0;
            r_state <= ST_RST_HOLD;
          end
        end
        ST_RST_HOLD: begin
          if (!w_lock_s) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == RST_LAST) begin
            r_cnt      <= '0;
            r_poll_cnt <= '0;
            r_arvalid  <= 1'b1;
            r_state    <= ST_POLL_AR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_POLL_AR: begin
          // Lock loss is remembered; the read still runs to completion.
          if (!w_lock_s) r_lost <= 1'b1;
          if (m_axil.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_POLL_R;
          end
        end
        ST_POLL_R: begin
          if (m_axil.rvalid) begin
            r_rready <= 1'b0;
            if (r_lost || !w_lock_s) begin
              r_lost     <= 1'b0;
              r_cnt      <= '0;
              r_poll_cnt <= '0;
              r_state    <= ST_IDLE;
            end else if (m_axil.rresp != AXIL_RESP_OKAY) begin
              r_seq_error <= 1'b1;
              r_state     <= ST_ERROR;
            end else if (w_cal_done) begin
              r_powerup_rstn <= 1'b1;
              r_start_config <= 1'b1;
              r_state        <= ST_READY;
            end else if (r_poll_cnt == POLL_LAST) begin
              r_poll_cnt  <= r_poll_cnt + PCNT_W'(1);
              r_seq_error <= 1'b1;
              r_state     <= ST_ERROR;
            end else begin
              r_poll_cnt <= r_poll_cnt + PCNT_W'(1);
              r_cnt      <= '0;
              r_state    <= ST_POLL_WAIT;
            end
          end else if (!w_lock_s) begin
            r_lost <= 1'b1;
          end
        end
        ST_POLL_WAIT: begin
          if (!w_lock_s) begin
            r_cnt      <= '0;
            r_poll_cnt <= '0;
            r_state    <= ST_IDLE;
          end else if (r_cnt == WAIT_LAST) begin
            r_cnt     <= '0;
            r_arvalid <= 1'b1;
            r_state   <= ST_POLL_AR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_READY: begin
          if (!w_lock_s) begin
            r_powerup_rstn <= 1'b0;
            r_cnt          <= '0;
            r_poll_cnt     <= '0;
            r_state        <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          r_seq_error <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axil.arvalid = r_arvalid;
  assign m_axil.araddr  = CAL_ADDR;
  assign m_axil.rready  = r_rready;
  assign o_powerup_rstn = r_powerup_rstn;
  assign o_start_config = r_start_config;
  assign o_seq_error    = r_seq_error;
  assign o_seq_state    = r_state;

endmodule

// File: tb/tb_hbm_powerup_sequencer.sv
// Directed-plus-random bench for hbm_powerup_sequencer with an AXI-Lite read responder
// and a read-outcome/timing reference model.
module tb_hbm_powerup_sequencer;

  localparam int          RST   = 300;
  localparam int          PI    = 256;
  localparam int          PM    = 4;
  localparam logic [31:0] CADDR = 32'h0010_0000;
  localparam logic [31:0] CMASK = 32'h0000_0003;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       lock = 1'b0;
  logic       o_powerup_rstn, o_start_config, o_seq_error;
  logic [2:0] o_seq_state;
  int         cyc  = 0;

  hbm_powerup_sequencer_if m_axil ();

  hbm_powerup_sequencer #(
    .RST_CYCLES    (RST),
    .POLL_INTERVAL (PI),
    .POLL_MAX      (PM),
    .CAL_ADDR      (CADDR),
    .CAL_MASK      (CMASK)
  ) dut (
    .axis_clk         (clk),
    .axis_rstn        (rstn),
    .i_hbm_clk_locked (lock),
    .m_axil           (m_axil),
    .o_powerup_rstn   (o_powerup_rstn),
    .o_start_config   (o_start_config),
    .o_seq_error      (o_seq_error),
    .o_seq_state      (o_seq_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_data[$];
  logic [1:0]  q_resp[$];
  int          q_d[$];
  int          q_l[$];
  int          ar_edges[$];
  bit force_ar_low, outstanding, prev_arv, prev_hs, prev_beat, prev_sc, prev_pu;
  int ar_wait_left, r_wait_left;
  int ar_cnt, sc_cnt, sc_long, pu_rise, arv_drop, addr_bad, rdy_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    ar_cnt = 0; sc_cnt = 0; sc_long = 0; pu_rise = -1;
    arv_drop = 0; addr_bad = 0; rdy_bad = 0;
    ar_edges.delete();
  endtask

  task automatic clear_bus();
    m_axil.arready = 1'b0; m_axil.rvalid = 1'b0;
    m_axil.rdata = '0; m_axil.rresp = 2'b00;
    outstanding = 0; prev_arv = 0; prev_hs = 0; prev_beat = 0; prev_sc = 0; prev_pu = 0;
    ar_wait_left = 0; r_wait_left = 0; force_ar_low = 0;
    q_data.delete(); q_resp.delete(); q_d.delete(); q_l.delete();
  endtask

  // One cycle: observe at the falling edge, then drive the slave side for the next rising edge.
  task automatic tick();
    bit hs;
    @(negedge clk);
    if (m_axil.arvalid && m_axil.araddr !== CADDR) addr_bad++;
    if (prev_arv && !prev_hs && !m_axil.arvalid) arv_drop++;
    if (m_axil.rready && !outstanding) rdy_bad++;
    if (o_start_config) begin
      sc_cnt++;
      if (prev_sc) sc_long++;
    end
    if (o_powerup_rstn && !prev_pu && pu_rise < 0) pu_rise = cyc;
    prev_sc = o_start_config;
    prev_pu = o_powerup_rstn;
    if (prev_beat) begin
      m_axil.rvalid = 1'b0;
      outstanding   = 0;
    end
    if (outstanding && !m_axil.rvalid) begin
      if (r_wait_left == 0) begin
        m_axil.rvalid = 1'b1;
        m_axil.rdata  = (q_data.size() > 0) ? q_data.pop_front() : 32'h0;
        m_axil.rresp  = (q_resp.size() > 0) ? q_resp.pop_front() : 2'b00;
      end else begin
        r_wait_left--;
      end
    end
    if (m_axil.arvalid && !prev_arv) ar_wait_left = (q_d.size() > 0) ? q_d.pop_front() : 0;
    if (!m_axil.arvalid || force_ar_low) begin
      m_axil.arready = 1'b0;
    end else if (ar_wait_left > 0) begin
      m_axil.arready = 1'b0;
      ar_wait_left--;
    end else begin
      m_axil.arready = 1'b1;
    end
    hs = m_axil.arvalid && m_axil.arready;
    if (hs) begin
      ar_cnt++;
      ar_edges.push_back(cyc + 1);
      outstanding = 1;
      r_wait_left = (q_l.size() > 0) ? q_l.pop_front() : 0;
    end
    prev_beat = m_axil.rvalid && m_axil.rready;
    prev_hs   = hs;
    prev_arv  = m_axil.arvalid;
  endtask

  // Outcome of a calibration poll sequence, from the read-by-read rules.
  function automatic void model(input logic [31:0] dat[$], input logic [1:0] rsp[$],
                                output int n_ar, output int fin, output int err);
    logic [31:0] d;
    logic [1:0]  r;
    n_ar = 0; fin = 6; err = 1;
    for (int i = 0; i < PM; i++) begin
      n_ar = i + 1;
      d = (i < dat.size()) ? dat[i] : 32'h0;
      r = (i < rsp.size()) ? rsp[i] : 2'b00;
      if (r != 2'b00) return;
      if ((d & CMASK) == CMASK) begin
        fin = 5; err = 0;
        return;
      end
    end
  endfunction

  // Edge at which powerup_rstn rises: sync + hold, then per read AR wait, AR beat,
  // R latency, R beat, with POLL_INTERVAL idle cycles between reads.
  function automatic int exp_rise(input int l1, input int n, input int d[$], input int l[$]);
    int t;
    t = l1 + 2 + RST;
    for (int i = 0; i < n; i++)
      t += ((i < d.size()) ? d[i] : 0) + ((i < l.size()) ? l[i] : 0) + 2;
    t += (n - 1) * PI;
    return t;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_arvalid"}, 32'(m_axil.arvalid), 32'd0);
    check({tag, "_rready"},  32'(m_axil.rready),  32'd0);
    check({tag, "_araddr"},  m_axil.araddr,       CADDR);
    check({tag, "_pu"},      32'(o_powerup_rstn), 32'd0);
    check({tag, "_sc"},      32'(o_start_config), 32'd0);
    check({tag, "_err"},     32'(o_seq_error),    32'd0);
    check({tag, "_state"},   32'(o_seq_state),    32'd0);
  endtask

  task automatic bringup(input string tag, input logic [31:0] dat[$], input logic [1:0] rsp[$],
                         input int d[$], input int l[$], input bit via_rst);
    int n_ar, fin, err, l1, exp_pu, min_gap;
    model(dat, rsp, n_ar, fin, err);
    clear_stats();
    q_data = dat; q_resp = rsp; q_d = d; q_l = l;
    tick();
    if (via_rst) rstn = 1'b1;
    else lock = 1'b1;
    l1 = cyc + 1;
    repeat (RST + PM * (PI + 12) + 40) tick();
    exp_pu = (fin == 5) ? exp_rise(l1, n_ar, d, l) : -1;
    check({tag, "_nar"},   32'(ar_cnt),        32'(n_ar));
    check({tag, "_state"}, 32'(o_seq_state),   32'(fin));
    check({tag, "_err"},   32'(o_seq_error),   32'(err));
    check({tag, "_pu"},    32'(o_powerup_rstn), (fin == 5) ? 32'd1 : 32'd0);
    check({tag, "_rise"},  32'(pu_rise),       32'(exp_pu));
    check({tag, "_scn"},   32'(sc_cnt),        (fin == 5) ? 32'd1 : 32'd0);
    check({tag, "_scl"},   32'(sc_long),       32'd0);
    check({tag, "_proto"}, 32'(arv_drop + addr_bad + rdy_bad), 32'd0);
    if (ar_edges.size() > 1) begin
      min_gap = 1 << 30;
      for (int i = 1; i < ar_edges.size(); i++)
        if (ar_edges[i] - ar_edges[i-1] < min_gap) min_gap = ar_edges[i] - ar_edges[i-1];
      check({tag, "_gap"}, 32'(min_gap >= PI + 2), 32'd1);
    end
  endtask

  task automatic drop_lock(input string tag, input bit chk);
    tick();
    lock = 1'b0;
    repeat (3) tick();
    if (chk) begin
      check({tag, "_pu"},    32'(o_powerup_rstn), 32'd0);
      check({tag, "_state"}, 32'(o_seq_state),    32'd0);
    end
    repeat (3) tick();
  endtask

  task automatic hard_reset();
    tick();
    rstn = 1'b0;
    lock = 1'b0;
    clear_bus();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dat[$];
    logic [1:0]  rsp[$];
    int          dd[$];
    int          ll[$];
    int          k;

    clear_bus();
    clear_stats();
    repeat (3) tick();
    check_reset_vals("rst");
    rstn = 1'b1;
    tick();

    // Normal bring-up, first read calibrated.
    dat = '{$urandom() | 32'h3}; rsp = '{2'b00}; dd = '{0}; ll = '{0};
    bringup("normal", dat, rsp, dd, ll, 0);
    drop_lock("lossready", 1);

    // Delayed calibration 0x0, 0x1, 0x3 with random handshake delays.
    dat = '{32'h0, 32'h1, 32'h3}; rsp = '{2'b00, 2'b00, 2'b00};
    dd.delete(); ll.delete();
    for (int i = 0; i < 3; i++) begin
      dd.push_back($urandom_range(0, 3));
      ll.push_back($urandom_range(0, 3));
    end
    bringup("delayed", dat, rsp, dd, ll, 0);
    drop_lock("loss2", 1);

    // Random number of uncalibrated reads before success.
    k = $urandom_range(0, 3);
    dat.delete(); rsp.delete(); dd.delete(); ll.delete();
    for (int i = 0; i < k; i++) begin
      dat.push_back(($urandom() & ~32'h3) | 32'($urandom_range(0, 2)));
      rsp.push_back(2'b00);
    end
    dat.push_back($urandom() | 32'h3); rsp.push_back(2'b00);
    for (int i = 0; i <= k; i++) begin
      dd.push_back($urandom_range(0, 2));
      ll.push_back($urandom_range(0, 2));
    end
    bringup("random", dat, rsp, dd, ll, 0);
    drop_lock("loss3", 1);

    // Timeout: calibration never completes.
    dat.delete(); rsp.delete(); dd.delete(); ll.delete();
    for (int i = 0; i < PM + 2; i++) begin
      dat.push_back(($urandom() & ~32'h3) | 32'h1);
      rsp.push_back(2'b00);
    end
    bringup("timeout", dat, rsp, dd, ll, 0);
    drop_lock("errlock", 0);
    check("sticky_state", 32'(o_seq_state), 32'd6);
    check("sticky_err",   32'(o_seq_error), 32'd1);
    hard_reset();
    check_reset_vals("rst2");

    // Slave error on the first read.
    dat = '{32'h3}; rsp = '{2'b10}; dd = '{0}; ll = '{0};
    bringup("slverr", dat, rsp, dd, ll, 0);
    hard_reset();

    // Lock loss while AR is stalled: AR must complete, then IDLE, result discarded.
    clear_stats();
    force_ar_low = 1;
    q_data = '{32'h3}; q_resp = '{2'b00};
    tick();
    lock = 1'b1;
    for (int i = 0; i < RST + 20; i++) begin
      tick();
      if (m_axil.arvalid) break;
    end
    check("stall_issue", 32'(m_axil.arvalid), 32'd1);
    lock = 1'b0;
    repeat (10) tick();
    check("stall_hold",  32'(m_axil.arvalid), 32'd1);
    check("stall_state", 32'(o_seq_state),    32'd2);
    force_ar_low = 0;
    repeat (10) tick();
    check("abort_nar",   32'(ar_cnt),         32'd1);
    check("abort_state", 32'(o_seq_state),    32'd0);
    check("abort_pu",    32'(o_powerup_rstn), 32'd0);
    check("abort_sc",    32'(sc_cnt),         32'd0);
    check("abort_proto", 32'(arv_drop + addr_bad + rdy_bad), 32'd0);
    dat = '{32'h3}; rsp = '{2'b00}; dd = '{0}; ll = '{0};
    bringup("relock", dat, rsp, dd, ll, 0);
    drop_lock("loss4", 1);

    // Reset asserted in POLL_R, then restart from IDLE with lock still high.
    clear_stats();
    q_data = '{32'h3}; q_resp = '{2'b00}; q_l = '{30};
    tick();
    lock = 1'b1;
    for (int i = 0; i < RST + 20; i++) begin
      tick();
      if (o_seq_state == 3'd3) break;
    end
    check("midpoll_reach", 32'(o_seq_state), 32'd3);
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    clear_bus();
    tick();
    dat = '{32'h3}; rsp = '{2'b00}; dd = '{0}; ll = '{0};
    bringup("restart", dat, rsp, dd, ll, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hbm_powerup_sequencer.md
# hbm_powerup_sequencer

Sequences HBM bring-up in the RecoNIC HBM simulation and shell. It holds the HBM subsystem in reset for a fixed number of cycles once the HBM clock reports lock. It then polls the HBM calibration status register over an AXI-Lite read-only master until calibration completes. Finally it releases `powerup_rstn` and pulses `start_config` so the RDMA configuration driver can begin. It sits between the HBM clock generator / `open_nic_shell` status path and the test driver.

## Interface
- `RST_CYCLES`, 15000: reset hold length in `axis_clk` cycles; 60 us at 250 MHz.
- `POLL_INTERVAL`, 256: idle cycles between calibration reads.
- `POLL_MAX`, 64: maximum number of calibration reads before the sequencer declares a timeout.
- `CAL_ADDR`, 32'h0010_0000: AXI-Lite address of the calibration status register.
- `CAL_MASK`, 32'h0000_0003: bits that must all read 1 for calibration to count as done.
- `axis_clk`  in  1  clock.
- `axis_rstn`  in  1  reset; asynchronous, active-low; clock `axis_clk`.
- `hbm_clk_locked`  in  1  asynchronous lock indication from the HBM clock generator.
- `m_axil_arvalid`  out  1  read address valid.
- `m_axil_araddr`  out  32  read address; always `CAL_ADDR` while `m_axil_arvalid` is high.
- `m_axil_arready`  in  1  read address ready.
- `m_axil_rvalid`  in  1  read data valid.
- `m_axil_rdata`  in  32  read data.
- `m_axil_rresp`  in  2  read response.
- `m_axil_rready`  out  1  read data ready.
- `powerup_rstn`  out  1  active-low reset to `open_nic_shell`; high only in READY.
- `start_config`  out  1  one-cycle pulse on entry to READY.
- `seq_error`  out  1  sticky error flag; set on timeout or on a non-OKAY response.
- `seq_state`  out  3  current state encoding, for debug.

## Operation
- `hbm_clk_locked` passes through a 2-flop synchronizer; `lock_s` is the synchronized value.
- States and encodings: IDLE=0, RST_HOLD=1, POLL_AR=2, POLL_R=3, POLL_WAIT=4, READY=5, ERROR=6.
- IDLE: when `lock_s` is high, clear the cycle counter and go to RST_HOLD.
- RST_HOLD: increment the counter each cycle. When the counter reaches `RST_CYCLES-1`, clear the poll count and go to POLL_AR.
- POLL_AR: hold `m_axil_arvalid`=1. When `m_axil_arready` is sampled high, go to POLL_R.
- POLL_R: hold `m_axil_rready`=1. On `m_axil_rvalid`:
  - `m_axil_rresp`≠0: go to ERROR.
  - `(m_axil_rdata & CAL_MASK) == CAL_MASK`: go to READY.
  - Otherwise increment the poll count. If the poll count equals `POLL_MAX`, go to ERROR; else go to POLL_WAIT.
- POLL_WAIT: count `POLL_INTERVAL` cycles, then go to POLL_AR.
- READY: `powerup_rstn`=1. The sequencer stays in READY until lock is lost.
- ERROR: `seq_error`=1. The only exit is `axis_rstn`.
- Lock loss: `lock_s` falling in RST_HOLD, POLL_WAIT or READY forces IDLE on the next cycle. `powerup_rstn` drops in that same cycle and counters clear.
- Lock loss in POLL_AR or POLL_R: the sequencer first completes the outstanding handshake, then goes to IDLE and discards the read result. It never abandons AXI mid-transaction.
- Counter widths are `$clog2` of the parameter plus 1. Counters saturate and never wrap.
- `seq_error` clears only on `axis_rstn`.

## Timing
- Reset values:
  - State is IDLE, and all counters and synchronizer flops are 0.
  - `m_axil_arvalid`=0, `m_axil_rready`=0, `m_axil_araddr`=`CAL_ADDR`.
  - `powerup_rstn`=0, `start_config`=0, `seq_error`=0, `seq_state`=0.
- All outputs are registered.
- Lock to RST_HOLD entry takes 3 cycles: 2 synchronizer cycles plus 1 state transition.
- RST_HOLD lasts exactly `RST_CYCLES` cycles.
- `m_axil_arvalid` stays high until the handshake completes. It deasserts in the cycle after `arready` is sampled high, and `araddr` is stable throughout.
- `m_axil_rready` is high only in POLL_R.
- If `rvalid` arrives in the same cycle as the AR handshake, it is ignored; `rvalid` is accepted only in POLL_R.
- Minimum time between successive AR issues is `POLL_INTERVAL`+2 cycles.
- `powerup_rstn` rises in the cycle after the successful R beat, and `start_config` is high in that same single cycle.
- Asserting `axis_rstn` low mid-poll returns the sequencer to reset values immediately. The bench must not expect the pending R beat to be consumed.

## Structure
- Shared package `rn_hbm_pkg`:
  - `hbm_seq_state_t` enum with the encodings above.
  - `AXIL_RESP_OKAY`=2'b00.
  - Default `CAL_ADDR` and `CAL_MASK` constants.
- Sub-module `sync_2ff` (1-bit, reset to 0) for `hbm_clk_locked`. Everything else is one FSM plus two counters in a single module.

## Test plan
- Normal bring-up: lock at t0, first read returns 0x3 → exactly one AR to 0x0010_0000, `start_config` a single 1-cycle pulse, `powerup_rstn` high 15000+5 cycles after lock plus read latency.
- Delayed calibration: rdata sequence 0x0, 0x1, 0x3 → 3 ARs spaced at least 258 cycles apart, READY after the third read, `seq_error`=0.
- Timeout: rdata always 0x1, `POLL_MAX`=4 → 4 ARs, then ERROR (`seq_state`=6), `seq_error`=1, `powerup_rstn` stays 0 and never pulses `start_config`.
- Slave error: `rresp`=2'b10 on the first read → ERROR, `seq_error`=1, no further ARs.
- Lock loss: drop lock while in READY → `powerup_rstn` 0 within 3 cycles. Drop lock with `arready` held low in POLL_AR → `arvalid` held until `arready`=1, then IDLE. Re-lock → full `RST_CYCLES` hold repeats.
- Mid-poll reset: `axis_rstn` low in POLL_R → all outputs at reset values in the same cycle. After release, the sequence restarts from IDLE.
